// File: rtl/alu_pkg.sv
// Shared definitions for the ALU input sequencer: state encodings and default widths.
package alu_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_SHOW   = 3'd5
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with a per-instance reset value for the delay register.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge Clk) begin
    if (Reset) din_d <= RST_VAL;
    else       din_d <= din;
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/alu_input_sequencer.sv
// Button-driven sequencer that collects two operands and an opcode, launches the ALU
// and latches its result. Optional inactivity timeout enabled by ALU_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------
// GET_A     | waiting for enter to capture operand A
// GET_B     | waiting for enter to capture operand B
// GET_OP    | waiting for enter to capture the opcode
// START     | one-cycle ALU launch (alu_start high)
// WAIT      | waiting for alu_done
// SHOW      | result displayed; enter returns to GET_A
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                pb_enter,
  input  logic                pb_clear,
  input  logic [DATA_W-1:0]   sw_in,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_start,
  output logic [2*DATA_W-1:0] result_out,
  output logic                result_valid,
  output logic [2:0]          state_out,
  output logic                timeout_flag
);

  state_t state, next_state;
  logic   enter_ev, clear_ev;
  logic   cap_a, cap_b, cap_op, launch, latch_res, do_clear;
  logic   timeout_hit;

  // Delay registers reset to 1 so a button held through reset gives no event.
  edge_detect #(.RST_VAL(1'b1)) u_enter_ed (
    .Clk(Clk), .Reset(Reset), .din(pb_enter), .rise(enter_ev)
  );

  edge_detect #(.RST_VAL(1'b1)) u_clear_ed (
    .Clk(Clk), .Reset(Reset), .din(pb_clear), .rise(clear_ev)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_GET_A;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    launch     = 1'b0;
    latch_res  = 1'b0;
    do_clear   = 1'b0;
    if (clear_ev || timeout_hit) begin
      do_clear   = 1'b1;
      next_state = ST_GET_A;
    end else begin
      case (state)
        ST_GET_A:  if (enter_ev) begin cap_a  = 1'b1; next_state = ST_GET_B;  end
        ST_GET_B:  if (enter_ev) begin cap_b  = 1'b1; next_state = ST_GET_OP; end
        ST_GET_OP: if (enter_ev) begin cap_op = 1'b1; next_state = ST_START;  end
        ST_START:  begin launch = 1'b1; next_state = ST_WAIT; end
        ST_WAIT:   if (alu_done) begin latch_res = 1'b1; next_state = ST_SHOW; end
        ST_SHOW:   if (enter_ev) next_state = ST_GET_A;
        default:   next_state = ST_GET_A;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || do_clear) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      if (cap_a)  alu_a  <= sw_in;
      if (cap_b)  alu_b  <= sw_in;
      if (cap_op) alu_op <= sw_in[OP_W-1:0];
      if (launch) result_valid <= 1'b0;
      if (latch_res) begin
        result_out   <= alu_result;
        result_valid <= 1'b1;
      end
    end
  end

  assign alu_start = (state == ST_START);
  assign state_out = state;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             counting;

  assign counting    = (state == ST_GET_B) || (state == ST_GET_OP) || (state == ST_SHOW);
  assign timeout_hit = counting && !enter_ev && !clear_ev &&
                       (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk) begin
    if (Reset)
      idle_cnt <= '0;
    else if (enter_ev || clear_ev || next_state == ST_GET_A)
      idle_cnt <= '0;
    else if (counting)
      idle_cnt <= idle_cnt + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset)            timeout_flag <= 1'b0;
    else if (timeout_hit) timeout_flag <= 1'b1;
    else if (enter_ev)    timeout_flag <= 1'b0;
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter DATA_W, default 4: operand width in bits.
REQ-002 Parameter OP_W, default 3: opcode width in bits.
REQ-003 Parameter TIMEOUT_CYC, default 500_000_000: inactivity limit in Clk cycles; used only with ALU_SEQ_TIMEOUT_EN.
REQ-004 Clk  input  1  system clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 pb_enter  input  1  debounced "enter" button level.
REQ-007 pb_clear  input  1  debounced "clear" button level.
REQ-008 sw_in  input  DATA_W  switch value, sampled as operand or opcode.
REQ-009 alu_done  input  1  ALU completion strobe.
REQ-010 alu_result  input  2*DATA_W  ALU result, valid when alu_done=1.
REQ-011 alu_a, alu_b  output  DATA_W each  registered operands to the ALU.
REQ-012 alu_op  output  OP_W  registered opcode, equal to sw_in[OP_W-1:0] at capture.
REQ-013 alu_start  output  1  one-cycle ALU launch pulse.
REQ-014 result_out  output  2*DATA_W  latched result.
REQ-015 result_valid  output  1  high while result_out is displayable.
REQ-016 state_out  output  3  current state encoding, for LEDs.
REQ-017 timeout_flag  output  1  sticky inactivity indicator; constant 0 without ALU_SEQ_TIMEOUT_EN.

Function
REQ-018 The block SHALL rising-edge-detect pb_enter and pb_clear with a one-cycle-delayed copy; an edge is a 1-cycle event (enter_ev, clear_ev).
REQ-019 The FSM SHALL have states GET_A=0, GET_B=1, GET_OP=2, START=3, WAIT=4, SHOW=5; codes 6–7 SHALL go to GET_A next cycle.
REQ-020 GET_A + enter_ev: alu_a <= sw_in, go GET_B; GET_B + enter_ev: alu_b <= sw_in, go GET_OP; GET_OP + enter_ev: alu_op <= sw_in[OP_W-1:0], go START.
REQ-021 START SHALL last exactly one cycle with alu_start=1, clear result_valid, and go to WAIT; alu_start SHALL be 0 in all other states.
REQ-022 WAIT + alu_done: result_out <= alu_result, result_valid <= 1, go SHOW; alu_done is ignored in every state except WAIT.
REQ-023 SHOW + enter_ev: go GET_A with alu_a/alu_b/alu_op retained and result_valid held until the next START.
REQ-024 enter_ev SHALL be ignored in START and WAIT (no queuing).
REQ-025 clear_ev in any state SHALL go to GET_A, zero alu_a, alu_b, alu_op, result_out, result_valid; clear_ev wins over a same-cycle enter_ev or alu_done.
REQ-026 Operand capture latency: alu_a/alu_b/alu_op update on the first Clk edge after the cycle in which enter_ev is high.

Reset
REQ-027 Reset SHALL set state GET_A; alu_a, alu_b, alu_op, result_out, timeout counter to 0; alu_start, result_valid, timeout_flag to 0.
REQ-028 Reset SHALL set both edge-detector delay registers to 1, so a button held through reset release produces no event.
REQ-029 Reset asserted mid-operation (incl. WAIT) SHALL abandon the operation; a later alu_done is ignored.

Configuration
REQ-030 With ALU_SEQ_TIMEOUT_EN defined, a counter SHALL clear on enter_ev, clear_ev, or entry to GET_A, and increment otherwise in GET_B, GET_OP, SHOW; at TIMEOUT_CYC-1 the FSM SHALL act as on clear_ev and set timeout_flag, which clears on the next enter_ev or Reset.
REQ-031 Without ALU_SEQ_TIMEOUT_EN no counter SHALL be built, the FSM never auto-returns, and timeout_flag is tied 0.

Structure
REQ-032 Shared package alu_pkg SHALL hold the state enum/encodings, default DATA_W and OP_W constants.
REQ-033 One sub-module edge_detect (per-instance reset value, 1-cycle rise pulse) SHALL be instantiated twice.

Verification
REQ-034 Reset, enter with sw_in=3, 5, 2 (opcode) -> alu_a=3, alu_b=5, alu_op=2, one alu_start pulse the cycle after entering START, state_out=4.
REQ-035 In WAIT drive alu_done with alu_result=8'h08 -> result_out=8'h08, result_valid=1, state_out=5; further alu_done pulses change nothing.
REQ-036 pb_enter held high across Reset release, and pb_enter pulses during START/WAIT -> no state change.
REQ-037 pb_clear and pb_enter rise in the same cycle in GET_OP -> GET_A, all operand/result registers 0.
REQ-038 Reset asserted during WAIT, then alu_done -> state GET_A, result_valid=0, result_out=0.
REQ-039 ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16: idle 16 cycles in GET_B -> GET_A, timeout_flag=1; next enter_ev -> timeout_flag=0.
